// File: rtl/mac_seq_sgn_pkg.sv
// Shared types, default sizes and helpers for the sequential signed MAC controller.
// Imported by the interface, the multiply-adder and the top.
package mac_seq_sgn_pkg;

    localparam int unsigned DefBw     = 8;
    localparam int unsigned DefAccW   = 2 * DefBw;
    localparam int unsigned DefMaxLen = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } state_e;

    // Longer commands are cut down to the maximum supported term count.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/mac_seq_sgn_if.sv
// Command, operand and result streams of the signed MAC controller.
// slave is the controller side; master is the producer/consumer side.
interface mac_seq_sgn_if #(
    parameter int unsigned BW   = 8,
    parameter int unsigned AccW = 16,
    parameter int unsigned LenW = 5
);

    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic [LenW-1:0]        cmd_len_i;
    logic signed [AccW-1:0] cmd_init_i;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic signed [BW-1:0]   in_x_i;
    logic signed [BW-1:0]   in_y_i;

    logic                   out_valid_o;
    logic                   out_ready_i;
    logic signed [AccW-1:0] out_sum_o;
    logic                   out_ovf_o;

    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_init_i,
        output cmd_ready_o,
        input  in_valid_i, in_x_i, in_y_i,
        output in_ready_o,
        output out_valid_o, out_sum_o, out_ovf_o,
        input  out_ready_i
    );

    modport master (
        output cmd_valid_i, cmd_len_i, cmd_init_i,
        input  cmd_ready_o,
        output in_valid_i, in_x_i, in_y_i,
        input  in_ready_o,
        input  out_valid_o, out_sum_o, out_ovf_o,
        output out_ready_i
    );

endinterface

// File: rtl/mac_seq_sgn_muladd.sv
// Combinational signed multiply-adder: p_o = x_i * y_i + a_i, wrapping to WidthA bits.
// The sign-extended product is exported so callers can build their own overflow check.
module mac_seq_sgn_muladd #(
    parameter int unsigned WidthX = 8,
    parameter int unsigned WidthY = 8,
    parameter int unsigned WidthA = 16
) (
    input  logic signed [WidthX-1:0] x_i,
    input  logic signed [WidthY-1:0] y_i,
    input  logic signed [WidthA-1:0] a_i,
    output logic signed [WidthA-1:0] prod_o,
    output logic signed [WidthA-1:0] p_o
);

    logic signed [WidthX+WidthY-1:0] w_prod;

    // Full-precision product; (-2^(W-1))^2 still fits in WidthX+WidthY bits.
    assign w_prod = x_i * y_i;
    assign prod_o = WidthA'(w_prod);
    assign p_o    = prod_o + a_i;

endmodule

// File: rtl/mac_seq_sgn.sv
// Sequential signed MAC controller: accumulates init + sum(X*Y) over a command of N pairs
// and returns the wrapped sum with a sticky signed-overflow flag.
module mac_seq_sgn
    import mac_seq_sgn_pkg::*;
#(
    parameter int unsigned BW     = DefBw,
    parameter int unsigned AccW   = DefAccW,
    parameter int unsigned MaxLen = DefMaxLen,
    parameter int unsigned LenW   = $clog2(MaxLen + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mac_seq_sgn_if.slave  bus
);

    state_e                 r_state, w_state_next;
    logic signed [AccW-1:0] r_acc, w_acc_next;
    logic [LenW-1:0]        r_cnt, w_cnt_next;
    logic                   r_ovf, w_ovf_next;

    logic signed [AccW-1:0] w_prod_ext;
    logic signed [AccW-1:0] w_madd;
    logic signed [AccW:0]   w_sum_wide;
    logic                   w_step_ovf;
    logic [LenW-1:0]        w_len_clamped;
    logic                   w_cmd_hs;
    logic                   w_in_hs;
    logic                   w_out_hs;

    mac_seq_sgn_muladd #(
        .WidthX (BW),
        .WidthY (BW),
        .WidthA (AccW)
    ) u_muladd (
        .x_i    (bus.in_x_i),
        .y_i    (bus.in_y_i),
        .a_i    (r_acc),
        .prod_o (w_prod_ext),
        .p_o    (w_madd)
    );

    // One extra bit of headroom: a mismatch between the top two bits means the wrap lost data.
    assign w_sum_wide = (AccW + 1)'(w_prod_ext) + (AccW + 1)'(r_acc);
    assign w_step_ovf = w_sum_wide[AccW] != w_sum_wide[AccW-1];

    assign w_len_clamped = LenW'(clamp_len(32'(bus.cmd_len_i), MaxLen));

    assign w_cmd_hs = bus.cmd_valid_i & bus.cmd_ready_o;
    assign w_in_hs  = bus.in_valid_i & bus.in_ready_o;
    assign w_out_hs = bus.out_valid_o & bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // Handshake outputs depend on the state only.
    always_comb begin
        bus.cmd_ready_o = 1'b0;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        unique case (r_state)
            StIdle:  bus.cmd_ready_o = 1'b1;
            StAcc:   bus.in_ready_o  = 1'b1;
            StDone:  bus.out_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        unique case (r_state)
            StIdle: begin
                if (w_cmd_hs) begin
                    w_acc_next   = bus.cmd_init_i;
                    w_ovf_next   = 1'b0;
                    w_cnt_next   = w_len_clamped;
                    w_state_next = (w_len_clamped == '0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                if (w_in_hs) begin
                    w_acc_next = w_madd;
                    w_cnt_next = r_cnt - LenW'(1);
                    w_ovf_next = r_ovf | w_step_ovf;
                    if (r_cnt == LenW'(1)) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                if (w_out_hs) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign bus.out_sum_o = r_acc;
    assign bus.out_ovf_o = r_ovf;

endmodule
